// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 Hz timing constants and pipeline types for the frame reader
package vga_pkg;
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] H_VIS  = 10'd640;
    localparam logic [CNT_W-1:0] H_FP   = 10'd16;
    localparam logic [CNT_W-1:0] H_SYNC = 10'd96;
    localparam logic [CNT_W-1:0] H_BP   = 10'd48;
    localparam logic [CNT_W-1:0] H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [CNT_W-1:0] V_VIS  = 10'd480;
    localparam logic [CNT_W-1:0] V_FP   = 10'd10;
    localparam logic [CNT_W-1:0] V_SYNC = 10'd2;
    localparam logic [CNT_W-1:0] V_BP   = 10'd33;
    localparam logic [CNT_W-1:0] V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int PIPE_DEPTH = 2;
    typedef struct packed {
        logic in_img;
        logic visible;
        logic hs;
        logic vs;
    } ctl_t;
    localparam ctl_t CTL_RST = '{in_img: 1'b0, visible: 1'b0, hs: 1'b1, vs: 1'b1};
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable divider, h/v counters, raw sync/visible and frame start pulse
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en_o,
    output logic             clk_25mhz_o,
    output logic [CNT_W-1:0] hc_o,
    output logic [CNT_W-1:0] vc_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             visible_o,
    output logic             frame_start_o
);
    logic             pix_en_q, clk_25_q, fs_q, fs_d, h_end, v_end;
    logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;

    // next counter values; vc advances only when hc wraps
    always_comb begin
        h_end = hc_q == H_TOT - 1'b1;
        v_end = vc_q == V_TOT - 1'b1;
        hc_d  = h_end ? '0 : hc_q + 1'b1;
        vc_d  = !h_end ? vc_q : (v_end ? '0 : vc_q + 1'b1);
        fs_d  = pix_en_q && hc_q == '0 && vc_q == '0;
    end

    // divider toggles every clk; counters step only on pixel-enable cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_en_q <= 1'b0;
            clk_25_q <= 1'b0;
            fs_q     <= 1'b0;
            hc_q     <= '0;
            vc_q     <= '0;
        end else begin
            pix_en_q <= !pix_en_q;
            clk_25_q <= pix_en_q;
            fs_q     <= fs_d;
            if (pix_en_q) begin
                hc_q <= hc_d;
                vc_q <= vc_d;
            end
        end
    end

    assign pix_en_o      = pix_en_q;
    assign clk_25mhz_o   = clk_25_q;
    assign hc_o          = hc_q;
    assign vc_o          = vc_q;
    assign hs_o          = !(hc_q >= H_VIS + H_FP && hc_q < H_VIS + H_FP + H_SYNC);
    assign vs_o          = !(vc_q >= V_VIS + V_FP && vc_q < V_VIS + V_FP + V_SYNC);
    assign visible_o     = hc_q < H_VIS && vc_q < V_VIS;
    assign frame_start_o = fs_q;
endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans a 256x256 grayscale buffer out of memory onto a 640x480 VGA DAC
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int                ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] ENC_BASE  = 18'h00000,
    parameter logic [ADDR_W-1:0] DEC_BASE  = 18'h10000,
    parameter int                IMG_LOG2W = 8,
    parameter int                IMG_LOG2H = 8,
    parameter int                X0        = 192,
    parameter int                Y0        = 112
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              selected,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              clk_25mhz,
    output logic              h_sync,
    output logic              v_sync,
    output logic              blank_n,
    output logic              sync_n,
    output logic [7:0]        rgb,
    output logic              frame_start
);
    logic                           pix_en, hs, vs, visible, fs, in_img, buf_sel_q, mem_rd_en_q;
    logic                           blank_n_q, h_sync_q, v_sync_q;
    logic [CNT_W-1:0]               hc, vc, hx, vy;
    logic [IMG_LOG2H+IMG_LOG2W:0]   offset;
    logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
    logic [7:0]                     rgb_q;
    ctl_t                           ctl_d, ctl_out;
    ctl_t                           ctl_q [PIPE_DEPTH-1];

    vga_timing_gen u_tg (
        .clk          (clk),
        .rst          (rst),
        .pix_en_o     (pix_en),
        .clk_25mhz_o  (clk_25mhz),
        .hc_o         (hc),
        .vc_o         (vc),
        .hs_o         (hs),
        .vs_o         (vs),
        .visible_o    (visible),
        .frame_start_o(fs)
    );

    // image-window test and fetch address; address holds outside the image
    always_comb begin
        hx         = hc - CNT_W'(X0);
        vy         = vc - CNT_W'(Y0);
        in_img     = hc >= CNT_W'(X0) && hx < CNT_W'(1 << IMG_LOG2W) &&
                     vc >= CNT_W'(Y0) && vy < CNT_W'(1 << IMG_LOG2H);
        offset     = {vy[IMG_LOG2H:0], hx[IMG_LOG2W-1:0]};
        mem_addr_d = in_img ? (buf_sel_q ? DEC_BASE : ENC_BASE) + ADDR_W'(offset) : mem_addr_q;
        ctl_d      = '{in_img: in_img, visible: visible, hs: hs, vs: vs};
    end

    // buffer choice only changes at frame start so a frame never mixes buffers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            buf_sel_q <= 1'b0;
        else if (fs)
            buf_sel_q <= selected;
    end

    // stage 0 fetch plus control delay line matching the memory read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            for (int i = 0; i < PIPE_DEPTH - 1; i++) ctl_q[i] <= CTL_RST;
        end else if (pix_en) begin
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= in_img;
            ctl_q[0]    <= ctl_d;
            for (int i = 1; i < PIPE_DEPTH - 1; i++) ctl_q[i] <= ctl_q[i-1];
        end
    end

    assign ctl_out = ctl_q[PIPE_DEPTH-2];

    // output stage: pixel data gated by the delayed image flag, syncs aligned with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q     <= 8'h00;
            blank_n_q <= 1'b0;
            h_sync_q  <= 1'b1;
            v_sync_q  <= 1'b1;
        end else if (pix_en) begin
            rgb_q     <= ctl_out.in_img ? mem_rdata : 8'h00;
            blank_n_q <= ctl_out.visible;
            h_sync_q  <= ctl_out.hs;
            v_sync_q  <= ctl_out.vs;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign rgb         = rgb_q;
    assign blank_n     = blank_n_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign sync_n      = 1'b0;
    assign frame_start = fs;
endmodule
